// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU port A, load port B) for the single regfile write port; 1-cycle registered output,
// never backpressures (one write/cycle), stall zeroes both readies. WB_COALESCE_EN merges same-dest conflicts into one write.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 16,
    parameter int REG_AW   = 4,
    parameter int NUM_REGS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall,
    input  logic                a_valid,
    input  logic [REG_AW-1:0]   a_reg,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [REG_AW-1:0]   b_reg,
    input  logic [DATA_W-1:0]   b_data,
    output logic                b_ready,
    output logic                writing_to_reg,
    output logic [31:0]         wr_instr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err_range,
    output logic [7:0]          conflict_cnt
);

    localparam logic [REG_AW:0] LP_NREGS = (REG_AW + 1)'(NUM_REGS);

    logic                r_last_b;
    logic                r_wr_en;
    logic [31:0]         r_wr_instr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [NUM_REGS-1:0] r_busy;
    logic                r_err;
    logic [7:0]          r_cnt;

    logic                w_both;
    logic                w_coal;
    logic                w_grant_a;
    logic                w_grant_b;
    logic                w_xfer;
    logic [REG_AW-1:0]   w_dest;
    logic [DATA_W-1:0]   w_data;
    logic                w_in_range;
    logic [31:0]         w_instr;
    logic [NUM_REGS-1:0] w_onehot;

    assign w_both = a_valid && b_valid && !stall;

`ifdef WB_COALESCE_EN
    assign w_coal = w_both && (a_reg == b_reg) && ({1'b0, a_reg} < LP_NREGS);
`else
    assign w_coal = 1'b0;
`endif

    // A port wins when alone, when B had the last grant, or when both are merged.
    assign w_grant_a = !stall && a_valid && (!b_valid || r_last_b || w_coal);
    assign w_grant_b = !stall && b_valid && (!a_valid || !r_last_b || w_coal);
    assign w_xfer    = w_grant_a || w_grant_b;
    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;

    // B carries the payload on a merge: the load is later in program order.
    assign w_dest     = w_grant_b ? b_reg  : a_reg;
    assign w_data     = w_grant_b ? b_data : a_data;
    assign w_in_range = ({1'b0, w_dest} < LP_NREGS);
    assign w_onehot   = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_dest;

    always_comb begin
        w_instr = '0;
        w_instr[25 +: REG_AW] = w_dest;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_last_b   <= 1'b1;
            r_wr_en    <= 1'b0;
            r_wr_instr <= '0;
            r_wr_data  <= '0;
            r_busy     <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_wr_en <= w_xfer && w_in_range;
            r_busy  <= (w_xfer && w_in_range) ? w_onehot : '0;
            if (w_xfer && w_in_range) begin
                r_wr_instr <= w_instr;
                r_wr_data  <= w_data;
            end
            if (w_xfer && !w_in_range) begin
                r_err <= 1'b1;
            end
            if (w_xfer && !w_coal) begin
                r_last_b <= w_grant_b;
            end
            if (w_both && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign writing_to_reg = r_wr_en;
    assign wr_instr       = r_wr_instr;
    assign wr_data        = r_wr_data;
    assign busy_mask      = r_busy;
    assign err_range      = r_err;
    assign conflict_cnt   = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
    localparam int DATA_W   = 16;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                stall = 1'b0;
    logic                a_valid = 1'b0;
    logic [REG_AW-1:0]   a_reg = '0;
    logic [DATA_W-1:0]   a_data = '0;
    logic                a_ready;
    logic                b_valid = 1'b0;
    logic [REG_AW-1:0]   b_reg = '0;
    logic [DATA_W-1:0]   b_data = '0;
    logic                b_ready;
    logic                writing_to_reg;
    logic [31:0]         wr_instr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] busy_mask;
    logic                err_range;
    logic [7:0]          conflict_cnt;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_REGS(NUM_REGS)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .writing_to_reg(writing_to_reg), .wr_instr(wr_instr), .wr_data(wr_data),
        .busy_mask(busy_mask), .err_range(err_range), .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who won last, sticky error, conflict count, expected output stage.
    bit          m_last_was_b = 1'b1;
    bit          m_err = 1'b0;
    int          m_cnt = 0;
    bit          m_wr = 1'b0;
    logic [15:0] m_data = '0;
    logic [31:0] m_instr = '0;
    logic [7:0]  m_busy = '0;
    bit          acc_a, acc_b;
    int          n_writes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven; settle, check grants, predict, clock, check outputs.
    task automatic step();
        bit ga, gb, both, merge;
        int dest;
        logic [15:0] d;
        #1;
        both  = a_valid && b_valid && !stall;
        merge = 1'b0;
`ifdef WB_COALESCE_EN
        merge = both && (a_reg == b_reg) && (int'(a_reg) < NUM_REGS);
`endif
        ga = 1'b0;
        gb = 1'b0;
        if (stall) begin
        end else if (merge) begin
            ga = 1'b1; gb = 1'b1;
        end else if (a_valid && b_valid) begin
            if (m_last_was_b) ga = 1'b1; else gb = 1'b1;
        end else if (a_valid) begin
            ga = 1'b1;
        end else if (b_valid) begin
            gb = 1'b1;
        end
        check("a_ready", a_ready, ga);
        check("b_ready", b_ready, gb);
        acc_a = ga;
        acc_b = gb;
        if (!reset) begin
            m_wr = 0; m_data = '0; m_instr = '0; m_busy = '0;
            m_err = 0; m_cnt = 0; m_last_was_b = 1'b1;
        end else begin
            if (ga || gb) begin
                dest = gb ? int'(b_reg) : int'(a_reg);
                d    = gb ? b_data : a_data;
                if (dest < NUM_REGS) begin
                    m_wr = 1; m_data = d; m_instr = dest * 32'h0200_0000; m_busy = 8'(1 << dest);
                end else begin
                    m_wr = 0; m_busy = '0; m_err = 1;
                end
                if (!merge) m_last_was_b = gb;
            end else begin
                m_wr = 0; m_busy = '0;
            end
            if (both && m_cnt < 255) m_cnt++;
        end
        @(posedge clock);
        #1;
        check("writing_to_reg", writing_to_reg, m_wr);
        if (m_wr) n_writes++;
        check("wr_instr", wr_instr, m_instr);
        check("wr_data", wr_data, m_data);
        check("busy_mask", busy_mask, m_busy);
        check("err_range", err_range, m_err);
        check("conflict_cnt", conflict_cnt, m_cnt);
    endtask

    task automatic idle_inputs();
        a_valid = 0; b_valid = 0; stall = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    initial begin
        // Reset then a single A request.
        do_reset();
        a_valid = 1; a_reg = 4'd3; a_data = 16'h1234;
        step();
        check("single_instr", wr_instr, 32'h0600_0000);
        check("single_busy", busy_mask, 32'h0000_0008);
        idle_inputs();
        step();

        // Round-robin from reset: A,B,A,B with held payloads.
        do_reset();
        a_valid = 1; a_reg = 4'd1; a_data = 16'h0A01;
        b_valid = 1; b_reg = 4'd2; b_data = 16'h0B02;
        n_writes = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr_grant_a", acc_a, (i % 2 == 0));
        end
        check("rr_writes", n_writes, 4);
        check("rr_cnt", conflict_cnt, 4);
        idle_inputs();
        step();

        // Stall holds both off; A wins first afterwards.
        do_reset();
        a_valid = 1; a_reg = 4'd6; a_data = 16'h5A5A;
        b_valid = 1; b_reg = 4'd7; b_data = 16'hA5A5;
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        stall = 0;
        step();
        check("stall_release_a", acc_a, 1);
        idle_inputs();
        step();

        // Out-of-range destination: accepted, not written, sticky error.
        do_reset();
        b_valid = 1; b_reg = 4'd9; b_data = 16'hDEAD;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) step();
        check("err_sticky", err_range, 1);
        do_reset();
        check("err_cleared", err_range, 0);

        // Reset right after an acceptance drops the pending write.
        a_valid = 1; a_reg = 4'd5; a_data = 16'h5555;
        b_valid = 1; b_reg = 4'd0; b_data = 16'h0000;
        step();
        idle_inputs();
        reset = 0;
        step();
        reset = 1;
        step();

        // Same-destination conflict.
        do_reset();
        a_valid = 1; a_reg = 4'd4; a_data = 16'h00AA;
        b_valid = 1; b_reg = 4'd4; b_data = 16'h00BB;
        step();
`ifdef WB_COALESCE_EN
        check("coal_data", wr_data, 16'h00BB);
        idle_inputs();
`else
        check("first_data", wr_data, 16'h00AA);
        a_valid = 0;
        step();
        check("second_data", wr_data, 16'h00BB);
        b_valid = 0;
`endif
        step();

        // Continuous conflicts to saturate the counter.
        do_reset();
        for (int i = 0; i < 270; i++) begin
            if (i == 0 || acc_a) begin a_valid = 1; a_reg = 4'($urandom_range(0, 7)); a_data = 16'($urandom); end
            if (i == 0 || acc_b) begin b_valid = 1; b_reg = 4'($urandom_range(0, 7)); b_data = 16'($urandom); end
            step();
        end
        check("cnt_saturated", conflict_cnt, 255);

        // Random traffic with stalls, out-of-range destinations and occasional reset.
        do_reset();
        acc_a = 0; acc_b = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!a_valid || acc_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_reg   = 4'($urandom_range(0, 10));
                a_data  = 16'($urandom);
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_reg   = 4'($urandom_range(0, 10));
                b_data  = 16'($urandom);
            end
            stall = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1;
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback requesters: port A (ALU result) and port B (load/memory result).
- Uses round-robin priority and a valid/ready handshake on each port.
- Registers the winning write for one cycle, then drives `writing_to_reg` and a 32-bit instr-format word with the destination in bits [28:25], as the register file decodes it.
- Also reports pending-write status and conflict/error statistics to the core controller.

Parameters:
- DATA_W, 16, width of writeback data.
- REG_AW, 4, width of the destination register field.
- NUM_REGS, 8, number of implemented registers; destinations >= NUM_REGS are out of range.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- stall  in  1  controller hold; blocks all acceptance while 1.
- a_valid  in  1  port A request.
- a_reg  in  REG_AW  port A destination register.
- a_data  in  DATA_W  port A data.
- a_ready  out  1  port A accepted this cycle (combinational).
- b_valid  in  1  port B request.
- b_reg  in  REG_AW  port B destination register.
- b_data  in  DATA_W  port B data.
- b_ready  out  1  port B accepted this cycle (combinational).
- writing_to_reg  out  1  register-file write enable.
- wr_instr  out  32  bits [28:25] = destination; all other bits 0.
- wr_data  out  DATA_W  register-file write data.
- busy_mask  out  NUM_REGS  one-hot of the register being written this cycle.
- err_range  out  1  sticky flag: an out-of-range destination was accepted.
- conflict_cnt  out  8  saturating count of cycles where both ports were valid and not stalled.

Behaviour:
- Reset (reset==0 at clock edge): clears the output stage and all status.
  - writing_to_reg=0, wr_instr=0, wr_data=0, busy_mask=0, err_range=0, conflict_cnt=0.
  - last_grant=B, so A wins the first conflict.
  - Reset mid-operation drops any registered write; no write reaches the register file in the cycle after reset.
- Grant (combinational, stall==0):
  - Only one port valid: that port is granted.
  - Both valid: the port != last_grant is granted.
  - The granted port's ready=1; the other port's ready=0.
  - stall==1 or neither port valid: both readies 0.
  - last_grant updates to the granted port on every accepted transfer.
- Transfer: occurs on a clock edge where valid&&ready.
- Output stage: single register, latency exactly 1 cycle from acceptance to writing_to_reg=1.
  - The stage never backpressures, so throughput is one write per cycle.
  - With no transfer, next cycle writing_to_reg=0; wr_instr and wr_data hold their last values.
- Range check: transfer with dest >= NUM_REGS is accepted (ready=1) but not written.
  - writing_to_reg stays 0 the next cycle.
  - err_range sets and stays set until reset.
- busy_mask = (1<<dest) while writing_to_reg=1, else 0.
- conflict_cnt increments when a_valid&&b_valid&&!stall and saturates at 255.
- Requesters must hold valid and payload stable until ready; the arbiter does not check this.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: on a conflict where a_reg==b_reg (in range), both ports are accepted in the same cycle (a_ready=b_ready=1).
  - One write is issued with b_data, since the load is the later value in program order.
  - last_grant is unchanged; conflict_cnt still increments.
- Undefined: same-destination conflicts follow normal round-robin; two separate writes occur on consecutive grants.

Test Plan:
- Reset then single request: reset=0 for 2 cycles, release, a_valid=1 a_reg=3 a_data=16'h1234 → a_ready=1 in that cycle. Next cycle: writing_to_reg=1, wr_instr=32'h0600_0000, wr_data=16'h1234, busy_mask=8'b0000_1000.
- Round-robin: both valid for 4 cycles, a_reg=1, b_reg=2, payloads held until accepted → grants A,B,A,B. writing_to_reg high 4 consecutive cycles. conflict_cnt=4.
- Stall: both valid, stall=1 for 3 cycles → both readies 0, writing_to_reg=0. On release, A is granted first from reset state.
- Out of range: b_valid=1 b_reg=9 → b_ready=1, writing_to_reg stays 0 next cycle, err_range=1 and stays 1 until reset=0.
- Reset mid-operation: accept A (reg 5), assert reset=0 on the next edge → writing_to_reg=0, busy_mask=0, conflict_cnt=0 afterward.
- Coalesce (WB_COALESCE_EN defined): a_reg=b_reg=4, a_data=16'h00AA, b_data=16'h00BB → both readies 1. Next cycle: one write, wr_data=16'h00BB, busy_mask=8'b0001_0000. Without the macro: two writes, 16'h00AA then 16'h00BB.
